sdram_arbit: RTL

Command arbiter and pin multiplexer that sits directly downstream of the SDRAM power-up initialisation stage. It passes the initialisation command stream to the SDRAM pins until initialisation completes. After that it grants the SDRAM bus to exactly one of three requestors: auto-refresh, write burst or read burst. It drives the decoded command pins, address, bank and write-data output enable to the top-level tristate.

---
 rtl/sdram_arbit_if.sv | 77 +++++++
 rtl/sdram_arbit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sdram_arbit_if.sv
// rtl/sdram_arbit_if.sv - signal bundle between the init stage, requestors, arbiter and SDRAM pins
//
// Purpose: groups every non-clock, non-reset signal of sdram_arbit.
//   slave  modport: the arbiter (consumes commands and requests, drives pins and grants)
//   master modport: the upstream side (init stage, refresh/write/read blocks) and pin consumer
// Signals:
//   init_cmd/init_addr/flag_init_end             init stage command stream and done level
//   aref_req/aref_en/aref_end/aref_cmd/aref_addr refresh handshake, command and address
//   wr_req/wr_en/wr_end/wr_cmd/wr_addr/wr_bank   write handshake, command, address, bank
//   wr_data/wr_dq_oe                             write data and data-drive request
//   rd_req/rd_en/rd_end/rd_cmd/rd_addr/rd_bank   read handshake, command, address, bank
//   sdram_*                                      SDRAM pins and data tristate controls
//   arb_err                                      sticky watchdog error
interface sdram_arbit_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  logic              flag_init_end;

  logic              aref_req;
  logic              aref_en;
  logic              aref_end;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;

  logic              wr_req;
  logic              wr_en;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_bank;
  logic [DATA_W-1:0] wr_data;
  logic              wr_dq_oe;

  logic              rd_req;
  logic              rd_en;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_bank;

  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [1:0]        sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;

  logic              arb_err;

  modport slave (
    input  init_cmd, init_addr, flag_init_end,
    input  aref_req, aref_end, aref_cmd, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_addr, wr_bank, wr_data, wr_dq_oe,
    input  rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    output aref_en, wr_en, rd_en,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe,
    output arb_err
  );

  modport master (
    output init_cmd, init_addr, flag_init_end,
    output aref_req, aref_end, aref_cmd, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_addr, wr_bank, wr_data, wr_dq_oe,
    output rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    input  aref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_ba, sdram_addr, sdram_dq_out, sdram_dq_oe,
    input  arb_err
  );
endinterface

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command arbiter and pin multiplexer behind the init stage
//
// Purpose: forwards the init command stream until init completes, then grants the
// SDRAM bus to one of refresh / write / read (fixed priority), with a busy watchdog.
// Ports:
//   clk    system clock (shared with the init stage)
//   rst_n  asynchronous active-low reset
//   bus    sdram_arbit_if.slave: requests/commands in, grants, pins and arb_err out
module sdram_arbit #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16,
  parameter int BUSY_MAX = 1023
) (
  input logic         clk,
  input logic         rst_n,
  sdram_arbit_if.slave bus
);

  localparam int         CNT_W   = $clog2(BUSY_MAX + 1);
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {
    S_INIT,
    S_ARBIT,
    S_AREF,
    S_WRITE,
    S_READ
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  busy_cnt;
  logic              aref_en_q;
  logic              wr_en_q;
  logic              rd_en_q;
  logic              arb_err_q;

  logic              busy_end;
  logic              busy_exp;
  logic [3:0]        cmd;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        ba;
  logic              dq_oe;

  // Only the granted requestor's end strobe counts; the others are ignored.
  always_comb begin
    busy_end = 1'b0;
    case (state)
      S_AREF:  busy_end = bus.aref_end;
      S_WRITE: busy_end = bus.wr_end;
      S_READ:  busy_end = bus.rd_end;
      default: busy_end = 1'b0;
    endcase
  end

  // Expiry fires in the BUSY_MAX-th cycle of a grant, so a grant lasts at most BUSY_MAX cycles.
  assign busy_exp = (busy_cnt == CNT_W'(BUSY_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      busy_cnt  <= '0;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      arb_err_q <= 1'b0;
    end else begin
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      case (state)
        S_INIT: begin
          if (bus.flag_init_end) state <= S_ARBIT;
        end
        S_ARBIT: begin
          // Holding the counter at zero here is what clears it on grant entry.
          busy_cnt <= '0;
          if (bus.aref_req) begin
            state     <= S_AREF;
            aref_en_q <= 1'b1;
          end else if (bus.wr_req) begin
            state   <= S_WRITE;
            wr_en_q <= 1'b1;
          end else if (bus.rd_req) begin
            state   <= S_READ;
            rd_en_q <= 1'b1;
          end
        end
        S_AREF, S_WRITE, S_READ: begin
          if (busy_end) begin
            state <= S_ARBIT;
          end else if (busy_exp) begin
            state     <= S_ARBIT;
            arb_err_q <= 1'b1;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Pins are muxed straight from the registered state so sub-module command timing is preserved.
  always_comb begin
    cmd   = CMD_NOP;
    addr  = '0;
    ba    = 2'b00;
    dq_oe = 1'b0;
    case (state)
      S_INIT: begin
        cmd  = bus.init_cmd;
        addr = bus.init_addr;
      end
      S_AREF: begin
        cmd  = bus.aref_cmd;
        addr = bus.aref_addr;
      end
      S_WRITE: begin
        cmd   = bus.wr_cmd;
        addr  = bus.wr_addr;
        ba    = bus.wr_bank;
        dq_oe = bus.wr_dq_oe;
      end
      S_READ: begin
        cmd  = bus.rd_cmd;
        addr = bus.rd_addr;
        ba   = bus.rd_bank;
      end
      default: begin
        cmd = CMD_NOP;
      end
    endcase
  end

  assign bus.sdram_cke    = 1'b1;
  assign bus.sdram_cs_n   = cmd[3];
  assign bus.sdram_ras_n  = cmd[2];
  assign bus.sdram_cas_n  = cmd[1];
  assign bus.sdram_we_n   = cmd[0];
  assign bus.sdram_ba     = ba;
  assign bus.sdram_addr   = addr;
  assign bus.sdram_dq_out = bus.wr_data;
  assign bus.sdram_dq_oe  = dq_oe;
  assign bus.aref_en      = aref_en_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.rd_en        = rd_en_q;
  assign bus.arb_err      = arb_err_q;

endmodule
